// File: rtl/board_memory_if.sv
// board_memory_if: muxed board-memory request bus with its read data and count returns.
interface board_memory_if #(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 7
);
    logic [ADDR_W-1:0] addr_in;
    logic [1:0]        data_in;
    logic              wren_in;
    logic              clr_hints;
    logic [1:0]        rdata_out;
    logic              rvalid_out;
    logic              busy_out;
    logic              init_done;
    logic [CNT_W-1:0]  black_count;
    logic [CNT_W-1:0]  white_count;
    logic [CNT_W-1:0]  hint_count;
    modport master (
        output addr_in, data_in, wren_in, clr_hints,
        input  rdata_out, rvalid_out, busy_out, init_done, black_count, white_count, hint_count
    );
    modport slave (
        input  addr_in, data_in, wren_in, clr_hints,
        output rdata_out, rvalid_out, busy_out, init_done, black_count, white_count, hint_count
    );
endinterface

// File: rtl/board_memory.sv
// board_memory: 64-cell Othello board store with start-position init, hint-clear sweep and live counts.
module board_memory #(
    parameter int ADDR_W = 7,
    parameter int CELLS  = 64,
    parameter int CNT_W  = 7
) (
    input logic             clk,
    input logic             rst_n,
    board_memory_if.slave   bus
);
    localparam int PW = $clog2(CELLS);
    typedef enum logic [1:0] {INIT, IDLE, CLRH} state_e;
    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [1:0]       mem_q [CELLS];
    logic [1:0]       rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d, init_done_q, init_done_d;
    logic [CNT_W-1:0] black_q, black_d, white_q, white_d, hint_q, hint_d;
    logic             in_range, last, wr_en;
    logic [PW-1:0]    wr_addr;
    logic [1:0]       wr_data, old;
    assign in_range = bus.addr_in < ADDR_W'(CELLS);
    assign last     = ptr_q == PW'(CELLS - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            rdata_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            init_done_q <= 1'b0;
            black_q     <= '0;
            white_q     <= '0;
            hint_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            init_done_q <= init_done_d;
            black_q     <= black_d;
            white_q     <= white_d;
            hint_q      <= hint_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem_q[wr_addr] <= wr_data;
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q != IDLE) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = last ? IDLE : state_q;
        end else if (bus.clr_hints) begin
            state_d = CLRH;
            ptr_d   = '0;
        end
    end
    // Sweeps own the single write port; host writes only land in IDLE.
    always_comb begin
        wr_addr     = (state_q == IDLE) ? bus.addr_in[PW-1:0] : ptr_q;
        old         = mem_q[wr_addr];
        wr_data     = (state_q == CLRH) ? 2'b00 :
                      (state_q == IDLE) ? bus.data_in :
                      (ptr_q == 6'd27 || ptr_q == 6'd36) ? 2'b10 :
                      (ptr_q == 6'd28 || ptr_q == 6'd35) ? 2'b01 : 2'b00;
        wr_en       = (state_q == INIT) || (state_q == CLRH && old == 2'b11) ||
                      (state_q == IDLE && bus.wren_in && in_range);
        rvalid_d    = state_q == IDLE && !bus.wren_in;
        rdata_d     = !rvalid_d ? rdata_q : in_range ? mem_q[bus.addr_in[PW-1:0]] : 2'b00;
        init_done_d = init_done_q || (state_q == INIT && last);
        black_d     = black_q;
        white_d     = white_q;
        hint_d      = hint_q;
        if (state_q == INIT) begin
            black_d = last ? CNT_W'(2) : black_q;
            white_d = last ? CNT_W'(2) : white_q;
            hint_d  = last ? '0 : hint_q;
        end else if (wr_en) begin
            black_d = black_q - CNT_W'(old == 2'b01) + CNT_W'(wr_data == 2'b01);
            white_d = white_q - CNT_W'(old == 2'b10) + CNT_W'(wr_data == 2'b10);
            hint_d  = hint_q  - CNT_W'(old == 2'b11) + CNT_W'(wr_data == 2'b11);
        end
    end
    assign bus.rdata_out   = rdata_q;
    assign bus.rvalid_out  = rvalid_q;
    assign bus.busy_out    = state_q != IDLE;
    assign bus.init_done   = init_done_q;
    assign bus.black_count = black_q;
    assign bus.white_count = white_q;
    assign bus.hint_count  = hint_q;
endmodule
